// File: rtl/rl_pair_scheduler_pkg.sv
// rl_pair_scheduler_pkg: shared FSM encoding and default sizing for the pair scheduler
package rl_pair_scheduler_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam int DEF_REF_PARTICLE_NUM        = 100;
  localparam int DEF_REF_RAM_ADDR_WIDTH      = 7;
  localparam int DEF_NEIGHBOR_PARTICLE_NUM   = 100;
  localparam int DEF_NEIGHBOR_RAM_ADDR_WIDTH = 7;
  localparam int DEF_NUM_FILTER              = 4;
  localparam int DEF_DRAIN_CYCLES            = 32;
endpackage

// File: rtl/rl_pair_scheduler_if.sv
// rl_pair_scheduler_if: control inputs and pair-address outputs of the pair scheduler
interface rl_pair_scheduler_if import rl_pair_scheduler_pkg::*; #(
  parameter int NUM_FILTER              = DEF_NUM_FILTER,
  parameter int REF_RAM_ADDR_WIDTH      = DEF_REF_RAM_ADDR_WIDTH,
  parameter int NEIGHBOR_RAM_ADDR_WIDTH = DEF_NEIGHBOR_RAM_ADDR_WIDTH
);
  logic start;
  logic [NUM_FILTER-1:0] back_pressure;
  logic pipeline_busy;
  logic [REF_RAM_ADDR_WIDTH-1:0] ref_addr;
  logic [NUM_FILTER*NEIGHBOR_RAM_ADDR_WIDTH-1:0] neighbor_addr;
  logic [NUM_FILTER-1:0] pair_valid;
  logic busy;
  logic done;
  modport master (
    input  start, back_pressure, pipeline_busy,
    output ref_addr, neighbor_addr, pair_valid, busy, done
  );
  modport slave (
    output start, back_pressure, pipeline_busy,
    input  ref_addr, neighbor_addr, pair_valid, busy, done
  );
endinterface

// File: rtl/rl_pair_scheduler.sv
// rl_pair_scheduler: walks every (reference, neighbor-group) pair and waits for the pipeline to drain
module rl_pair_scheduler import rl_pair_scheduler_pkg::*; #(
  parameter int REF_PARTICLE_NUM        = DEF_REF_PARTICLE_NUM,
  parameter int REF_RAM_ADDR_WIDTH      = DEF_REF_RAM_ADDR_WIDTH,
  parameter int NEIGHBOR_PARTICLE_NUM   = DEF_NEIGHBOR_PARTICLE_NUM,
  parameter int NEIGHBOR_RAM_ADDR_WIDTH = DEF_NEIGHBOR_RAM_ADDR_WIDTH,
  parameter int NUM_FILTER              = DEF_NUM_FILTER,
  parameter int DRAIN_CYCLES            = DEF_DRAIN_CYCLES
) (
  input logic clk,
  input logic rst,
  rl_pair_scheduler_if.master bus
);
  localparam int RCW = $clog2(REF_PARTICLE_NUM + 1);
  localparam int NCW = $clog2(NEIGHBOR_PARTICLE_NUM + NUM_FILTER + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam int NW  = NEIGHBOR_RAM_ADDR_WIDTH;
  logic [1:0] state;
  logic [RCW-1:0] ref_cnt;
  logic [NCW-1:0] nb_base;
  logic [DCW-1:0] drain_cnt;
  logic [REF_RAM_ADDR_WIDTH-1:0] ref_addr;
  logic [NUM_FILTER*NW-1:0] neighbor_addr, lane_addr;
  logic [NUM_FILTER-1:0] pair_valid, lane_ok;
  logic stall, idle, last_nb, last_ref;
  // nb_base is wide enough for base+lane, so the range test sees the true index before truncation
  always_comb begin
    lane_addr = '0;
    lane_ok = '0;
    for (int k = 0; k < NUM_FILTER; k++) begin
      lane_addr[k*NW +: NW] = NW'(nb_base + NCW'(k));
      lane_ok[k] = (nb_base + NCW'(k)) < NCW'(NEIGHBOR_PARTICLE_NUM);
    end
  end
  assign stall = |bus.back_pressure;
  assign idle = !bus.pipeline_busy && !stall;
  assign last_nb = (nb_base + NCW'(NUM_FILTER)) >= NCW'(NEIGHBOR_PARTICLE_NUM);
  assign last_ref = ref_cnt == RCW'(REF_PARTICLE_NUM - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      ref_cnt <= '0;
      nb_base <= '0;
      drain_cnt <= '0;
      ref_addr <= '0;
      neighbor_addr <= '0;
      pair_valid <= '0;
    end else begin
      pair_valid <= '0;
      case (state)
        ST_IDLE: if (bus.start) begin
          state <= ST_ISSUE;
          ref_cnt <= '0;
          nb_base <= '0;
          drain_cnt <= '0;
        end
        ST_ISSUE: if (!stall) begin
          ref_addr <= REF_RAM_ADDR_WIDTH'(ref_cnt);
          neighbor_addr <= lane_addr;
          pair_valid <= lane_ok;
          nb_base <= last_nb ? '0 : nb_base + NCW'(NUM_FILTER);
          ref_cnt <= last_nb && !last_ref ? ref_cnt + RCW'(1) : ref_cnt;
          state <= last_nb && last_ref ? ST_DRAIN : ST_ISSUE;
        end
        ST_DRAIN: begin
          drain_cnt <= idle ? drain_cnt + DCW'(1) : '0;
          state <= idle && drain_cnt == DCW'(DRAIN_CYCLES - 1) ? ST_DONE : ST_DRAIN;
        end
        default: state <= bus.start ? ST_DONE : ST_IDLE;
      endcase
    end
  end
  assign bus.ref_addr = ref_addr;
  assign bus.neighbor_addr = neighbor_addr;
  assign bus.pair_valid = pair_valid;
  assign bus.busy = state == ST_ISSUE || state == ST_DRAIN;
  assign bus.done = state == ST_DONE;
endmodule
